// File: rtl/vc_test_arb_pkg.sv
// -----------------------------------------------------------------------------
// vc_test_arb_pkg
// Shared definitions for the round-robin test sink arbiter:
//   - id_width()  : requester-id width for a given requester count
//   - COUNT_W     : width of the delivered-message counter
//   - COUNT_SAT   : value at which the delivered-message counter saturates
//   - buf_state_e : occupancy state of the one-entry output buffer
// -----------------------------------------------------------------------------
package vc_test_arb_pkg;

  localparam int unsigned COUNT_W = 16;

  typedef logic [COUNT_W-1:0] count_t;

  localparam count_t COUNT_SAT = 16'hFFFF;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

  // Width of an index able to name every requester; a single requester
  // still gets a one-bit id so that the port never collapses to zero width.
  function automatic int id_width(input int num_reqs);
    if (num_reqs <= 1) begin
      return 1;
    end
    return $clog2(num_reqs);
  endfunction

endpackage

// File: rtl/vc_rr_arb_comb.sv
// -----------------------------------------------------------------------------
// vc_rr_arb_comb
// Purely combinational round-robin picker. Scans requesters starting at ptr
// (ptr, ptr+1, ... modulo p_num_reqs) and selects the first one asserting req.
//
// Ports:
//   req   in   p_num_reqs  request vector, bit i belongs to requester i
//   ptr   in   p_id_sz     highest-priority requester for this cycle
//   grant out  p_num_reqs  one-hot grant (all zero when nothing requests)
//   id    out  p_id_sz     encoded index of the granted requester
//   any   out  1           at least one requester is asserting req
// -----------------------------------------------------------------------------
module vc_rr_arb_comb
  import vc_test_arb_pkg::*;
#(
  parameter int p_num_reqs = 4,
  parameter int p_id_sz    = id_width(p_num_reqs)
) (
  input  logic [p_num_reqs-1:0] req,
  input  logic [p_id_sz-1:0]    ptr,
  output logic [p_num_reqs-1:0] grant,
  output logic [p_id_sz-1:0]    id,
  output logic                  any
);

  // rot[k] is the request of the requester k positions after ptr. Because
  // p_num_reqs is a power of two, the p_id_sz-bit sum wraps exactly modulo
  // p_num_reqs and needs no explicit modulo logic.
  logic [p_num_reqs-1:0] rot;
  logic [p_id_sz-1:0]    off;

  for (genvar gi = 0; gi < p_num_reqs; gi++) begin : g_rot
    logic [p_id_sz-1:0] src;
    assign src     = ptr + p_id_sz'(gi);
    assign rot[gi] = req[src];
  end

  // Priority encode the rotated vector; scanning downward lets the smallest
  // offset (closest to ptr) be the last, and therefore winning, assignment.
  always_comb begin
    off = '0;
    any = 1'b0;
    for (int k = p_num_reqs - 1; k >= 0; k--) begin
      if (rot[k]) begin
        off = p_id_sz'(k);
        any = 1'b1;
      end
    end
  end

  assign id = ptr + off;

  always_comb begin
    grant = '0;
    if (any) begin
      grant[id] = 1'b1;
    end
  end

endmodule

// File: rtl/vc_test_sink_arb.sv
// -----------------------------------------------------------------------------
// vc_test_sink_arb
// Merges p_num_reqs valid/ready message streams into one shared sink through
// a one-entry output buffer. Requesters are served round-robin; the buffer
// may be refilled in the same cycle it drains, so a stream can sustain one
// message per cycle while the sink stays ready.
//
// Ports:
//   clk      in   1                      sole clock, rising edge
//   reset    in   1                      asynchronous, active-low reset
//   in_val   in   p_num_reqs             per-requester valid
//   in_rdy   out  p_num_reqs             per-requester ready (at most one high)
//   in_msg   in   p_num_reqs*p_msg_sz    packed messages, requester i at
//                                        [i*p_msg_sz +: p_msg_sz]
//   out_val  out  1                      buffered message valid
//   out_rdy  in   1                      shared sink ready
//   out_msg  out  p_msg_sz               buffered message
//   out_id   out  p_id_sz                requester that produced out_msg
//   count    out  16                     delivered messages, saturating
// -----------------------------------------------------------------------------
module vc_test_sink_arb
  import vc_test_arb_pkg::*;
#(
  parameter int p_msg_sz   = 8,
  parameter int p_num_reqs = 4,
  parameter int p_id_sz    = id_width(p_num_reqs)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [p_num_reqs-1:0]          in_val,
  output logic [p_num_reqs-1:0]          in_rdy,
  input  logic [p_num_reqs*p_msg_sz-1:0] in_msg,
  output logic                           out_val,
  input  logic                           out_rdy,
  output logic [p_msg_sz-1:0]            out_msg,
  output logic [p_id_sz-1:0]             out_id,
  output logic [COUNT_W-1:0]             count
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  buf_state_e          state_reg;
  logic [p_msg_sz-1:0] msg_reg;
  logic [p_id_sz-1:0]  id_reg;
  logic [p_id_sz-1:0]  ptr_reg;
  count_t              count_reg;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic [p_num_reqs-1:0] grant;
  logic [p_id_sz-1:0]    grant_id;
  logic                  grant_any;

  vc_rr_arb_comb #(
    .p_num_reqs (p_num_reqs),
    .p_id_sz    (p_id_sz)
  ) u_arb (
    .req   (in_val),
    .ptr   (ptr_reg),
    .grant (grant),
    .id    (grant_id),
    .any   (grant_any)
  );

  logic                full;
  logic                can_accept;
  logic                in_xfer;
  logic                out_xfer;
  logic [p_msg_sz-1:0] sel_msg;
  logic [p_id_sz-1:0]  ptr_next;

  assign full       = (state_reg == BUF_FULL);
  // A full buffer can still accept when the sink takes the current entry in
  // the same edge; out_rdy only reaches in_rdy, never out_val.
  assign can_accept = !full || out_rdy;
  assign in_xfer    = grant_any && can_accept;
  assign out_xfer   = full && out_rdy;

  // Ready is forced low while reset is held so no requester sees a handshake
  // that the (held) registers cannot complete.
  assign in_rdy = (reset && can_accept) ? grant : '0;

  assign sel_msg  = in_msg[int'(grant_id) * p_msg_sz +: p_msg_sz];
  // Next scan starts just after the winner; p_id_sz-bit wrap gives the modulo.
  assign ptr_next = grant_id + p_id_sz'(1);

  // ---------------------------------------------------------------------------
  // Output buffer and round-robin pointer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= BUF_EMPTY;
      msg_reg   <= '0;
      id_reg    <= '0;
      ptr_reg   <= '0;
    end else begin
      if (in_xfer) begin
        // Covers both fill-from-empty and simultaneous drain-and-refill.
        state_reg <= BUF_FULL;
        msg_reg   <= sel_msg;
        id_reg    <= grant_id;
        ptr_reg   <= ptr_next;
      end else if (out_xfer) begin
        state_reg <= BUF_EMPTY;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Delivered-message counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (out_xfer && (count_reg != COUNT_SAT)) begin
      count_reg <= count_reg + count_t'(1);
    end
  end

  assign out_val = full;
  assign out_msg = msg_reg;
  assign out_id  = id_reg;
  assign count   = count_reg;

endmodule

// File: tb/tb_vc_test_sink_arb.sv
module tb_vc_test_sink_arb;

  logic        clk;
  logic        reset;
  logic [3:0]  in_val;
  logic [3:0]  in_rdy;
  logic [31:0] in_msg;
  logic        out_val;
  logic        out_rdy;
  logic [7:0]  out_msg;
  logic [1:0]  out_id;
  logic [15:0] count;

  int errors;
  int checks;

  vc_test_sink_arb #(
    .p_msg_sz   (8),
    .p_num_reqs (4),
    .p_id_sz    (2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .in_val  (in_val),
    .in_rdy  (in_rdy),
    .in_msg  (in_msg),
    .out_val (out_val),
    .out_rdy (out_rdy),
    .out_msg (out_msg),
    .out_id  (out_id),
    .count   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  task automatic set_msg(input int idx, input logic [7:0] v);
    in_msg[idx*8 +: 8] = v;
  endtask

  // Leaves the bench at a falling edge with reset released and inputs idle.
  task automatic apply_reset();
    @(negedge clk);
    reset   = 1'b0;
    in_val  = 4'b0000;
    out_rdy = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset   = 1'b0;
    in_val  = 4'b1111;
    out_rdy = 1'b1;
    in_msg  = 32'hD3D2D1D0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL reset_out_val: got %b expected 0", out_val); end
    checks++; if (out_msg !== 8'h00) begin errors++; $display("FAIL reset_out_msg: got %h expected 00", out_msg); end
    checks++; if (out_id !== 2'd0) begin errors++; $display("FAIL reset_out_id: got %0d expected 0", out_id); end
    checks++; if (count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (in_rdy !== 4'b0000) begin errors++; $display("FAIL reset_in_rdy: got %b expected 0000", in_rdy); end
    reset   = 1'b1;
    in_val  = 4'b0000;
    out_rdy = 1'b0;
    #1;
    checks++; if (in_rdy !== 4'b0000) begin errors++; $display("FAIL reset_idle_in_rdy: got %b expected 0000", in_rdy); end
    $display("reset: out_val=%b count=%0d in_rdy=%b", out_val, count, in_rdy);
  endtask

  task automatic test_single_stream();
    logic [7:0] exp_msg [3];
    exp_msg[0] = 8'h11; exp_msg[1] = 8'h22; exp_msg[2] = 8'h33;
    apply_reset();
    out_rdy = 1'b1;
    in_val  = 4'b0001;
    set_msg(0, exp_msg[0]);
    #1;
    checks++; if (in_rdy !== 4'b0001) begin errors++; $display("FAIL single_in_rdy: got %b expected 0001", in_rdy); end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      checks++; if (out_val !== 1'b1 || out_msg !== exp_msg[k] || out_id !== 2'd0) begin
        errors++; $display("FAIL single_out[%0d]: got val=%b msg=%h id=%0d expected val=1 msg=%h id=0", k, out_val, out_msg, out_id, exp_msg[k]);
      end
      $display("single: out_id=%0d out_msg=%h", out_id, out_msg);
      if (k < 2) set_msg(0, exp_msg[k+1]);
      else in_val = 4'b0000;
    end
    @(posedge clk);
    @(negedge clk);
    checks++; if (count !== 16'd3) begin errors++; $display("FAIL single_count: got %0d expected 3", count); end
    checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL single_drain: got out_val=%b expected 0", out_val); end
  endtask

  task automatic test_all_valid();
    logic [1:0] exp_id;
    logic [7:0] exp_msg;
    logic [3:0] exp_rdy;
    apply_reset();
    in_msg  = 32'hA3A2A1A0;
    in_val  = 4'b1111;
    out_rdy = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      exp_id  = 2'((k - 1) % 4);
      exp_msg = 8'hA0 + 8'(exp_id);
      exp_rdy = 4'b0001 << (k % 4);
      checks++; if (out_id !== exp_id || out_msg !== exp_msg || out_val !== 1'b1) begin
        errors++; $display("FAIL all_valid_out[%0d]: got id=%0d msg=%h val=%b expected id=%0d msg=%h val=1", k, out_id, out_msg, out_val, exp_id, exp_msg);
      end
      checks++; if (in_rdy !== exp_rdy) begin
        errors++; $display("FAIL all_valid_in_rdy[%0d]: got %b expected %b", k, in_rdy, exp_rdy);
      end
      $display("all_valid: out_id=%0d out_msg=%h in_rdy=%b", out_id, out_msg, in_rdy);
    end
    in_val = 4'b0000;
    @(posedge clk);
    @(negedge clk);
    checks++; if (count !== 16'd6 || out_val !== 1'b0) begin
      errors++; $display("FAIL all_valid_count: got count=%0d val=%b expected count=6 val=0", count, out_val);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    out_rdy = 1'b0;
    in_val  = 4'b0100;
    set_msg(2, 8'hAA);
    @(posedge clk);
    @(negedge clk);
    checks++; if (out_val !== 1'b1 || out_msg !== 8'hAA || out_id !== 2'd2) begin
      errors++; $display("FAIL bp_fill: got val=%b msg=%h id=%0d expected val=1 msg=aa id=2", out_val, out_msg, out_id);
    end
    set_msg(2, 8'hBB);
    set_msg(0, 8'hCC);
    in_val = 4'b0101;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      checks++; if (out_val !== 1'b1 || out_msg !== 8'hAA || out_id !== 2'd2 || in_rdy !== 4'b0000) begin
        errors++; $display("FAIL bp_hold[%0d]: got val=%b msg=%h id=%0d in_rdy=%b expected val=1 msg=aa id=2 in_rdy=0000", k, out_val, out_msg, out_id, in_rdy);
      end
      $display("backpressure: stall %0d out_msg=%h in_rdy=%b", k, out_msg, in_rdy);
    end
    out_rdy = 1'b1;
    #1;
    // ptr sits at 3 after the id-2 grant; scan 3 -> 0 reaches requester 0.
    checks++; if (in_rdy !== 4'b0001) begin errors++; $display("FAIL bp_release_in_rdy: got %b expected 0001", in_rdy); end
    @(posedge clk);
    @(negedge clk);
    checks++; if (out_msg !== 8'hCC || out_id !== 2'd0 || out_val !== 1'b1 || count !== 16'd1) begin
      errors++; $display("FAIL bp_refill: got msg=%h id=%0d val=%b count=%0d expected msg=cc id=0 val=1 count=1", out_msg, out_id, out_val, count);
    end
    in_val = 4'b0000;
    @(posedge clk);
    @(negedge clk);
    checks++; if (count !== 16'd2 || out_val !== 1'b0) begin
      errors++; $display("FAIL bp_drain: got count=%0d val=%b expected count=2 val=0", count, out_val);
    end
  endtask

  task automatic test_sparse();
    apply_reset();
    out_rdy = 1'b1;
    in_val  = 4'b0001;
    set_msg(0, 8'h5A);
    @(posedge clk);
    @(negedge clk);
    in_val = 4'b0000;
    @(posedge clk);
    @(negedge clk);
    // ptr is now 1; the only active requester is 0 and must not wait.
    in_val = 4'b0001;
    set_msg(0, 8'h5B);
    #1;
    checks++; if (in_rdy !== 4'b0001) begin errors++; $display("FAIL sparse_in_rdy: got %b expected 0001", in_rdy); end
    @(posedge clk);
    @(negedge clk);
    checks++; if (out_val !== 1'b1 || out_id !== 2'd0 || out_msg !== 8'h5B) begin
      errors++; $display("FAIL sparse_out: got val=%b id=%0d msg=%h expected val=1 id=0 msg=5b", out_val, out_id, out_msg);
    end
    $display("sparse: out_id=%0d out_msg=%h", out_id, out_msg);
    in_val = 4'b0000;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    // ptr back at 1 and untouched by idle cycles: requester 1 beats 0.
    in_val = 4'b0011;
    #1;
    checks++; if (in_rdy !== 4'b0010) begin errors++; $display("FAIL sparse_ptr_hold: got in_rdy=%b expected 0010", in_rdy); end
    in_val = 4'b0000;
    checks++; if (count !== 16'd2) begin errors++; $display("FAIL sparse_count: got %0d expected 2", count); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    out_rdy = 1'b1;
    in_val  = 4'b0001;
    set_msg(0, 8'h55);
    @(posedge clk);
    @(negedge clk);
    in_val = 4'b0010;
    set_msg(1, 8'h66);
    @(posedge clk);
    @(negedge clk);
    out_rdy = 1'b0;
    in_val  = 4'b0000;
    @(posedge clk);
    @(negedge clk);
    checks++; if (out_val !== 1'b1 || out_msg !== 8'h66 || out_id !== 2'd1 || count !== 16'd1) begin
      errors++; $display("FAIL mid_prefill: got val=%b msg=%h id=%0d count=%0d expected val=1 msg=66 id=1 count=1", out_val, out_msg, out_id, count);
    end
    in_msg = 32'hA3A2A1A0;
    in_val = 4'b1111;
    out_rdy = 1'b1;
    reset  = 1'b0;
    #1;
    checks++; if (out_val !== 1'b0 || count !== 16'd0 || out_msg !== 8'h00 || out_id !== 2'd0 || in_rdy !== 4'b0000) begin
      errors++; $display("FAIL mid_async_clear: got val=%b count=%0d msg=%h id=%0d in_rdy=%b expected all zero", out_val, count, out_msg, out_id, in_rdy);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (in_rdy !== 4'b0001) begin errors++; $display("FAIL mid_first_grant: got in_rdy=%b expected 0001", in_rdy); end
    @(posedge clk);
    @(negedge clk);
    checks++; if (out_id !== 2'd0 || out_msg !== 8'hA0) begin
      errors++; $display("FAIL mid_after_reset: got id=%0d msg=%h expected id=0 msg=a0", out_id, out_msg);
    end
    $display("reset_mid: out_id=%0d out_msg=%h", out_id, out_msg);
    in_val = 4'b0000;
    @(posedge clk);
    @(negedge clk);
    checks++; if (count !== 16'd1) begin errors++; $display("FAIL mid_count: got %0d expected 1", count); end
  endtask

  task automatic test_saturation();
    apply_reset();
    out_rdy = 1'b1;
    in_val  = 4'b0001;
    set_msg(0, 8'h77);
    // After the k-th rising edge, k-1 messages have been delivered.
    for (int k = 1; k <= 65538; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 65535) begin
        checks++; if (count !== 16'hFFFE) begin errors++; $display("FAIL sat_pre: got %h expected fffe", count); end
      end
      if (k == 65536) begin
        checks++; if (count !== 16'hFFFF) begin errors++; $display("FAIL sat_reach: got %h expected ffff", count); end
      end
      if (k == 65538) begin
        checks++; if (count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h expected ffff", count); end
      end
    end
    in_val = 4'b0000;
    @(posedge clk);
    @(negedge clk);
    checks++; if (count !== 16'hFFFF || out_val !== 1'b0) begin
      errors++; $display("FAIL sat_final: got count=%h val=%b expected count=ffff val=0", count, out_val);
    end
    $display("saturation: count=%h", count);
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    reset   = 1'b0;
    in_val  = 4'b0000;
    in_msg  = 32'h0;
    out_rdy = 1'b0;
    test_reset();
    test_single_stream();
    test_all_valid();
    test_backpressure();
    test_sparse();
    test_reset_mid();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vc_test_sink_arb.md
VC_TEST_SINK_ARB -- requirements
Module: vc_test_sink_arb

Interface
REQ-001 Parameter p_msg_sz, default 8: width of each message in bits.
REQ-002 Parameter p_num_reqs, default 4: number of requester streams; SHALL be a power of two, 2..8.
REQ-003 Parameter p_id_sz, default 2: requester-id width, SHALL equal log2(p_num_reqs).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 in_val  input  p_num_reqs  per-requester valid; bit i belongs to requester i.
REQ-007 in_rdy  output  p_num_reqs  per-requester ready; at most one bit high in any cycle.
REQ-008 in_msg  input  p_num_reqs*p_msg_sz  packed messages; requester i occupies bits [i*p_msg_sz +: p_msg_sz].
REQ-009 out_val  output  1  buffered message valid toward the shared sink.
REQ-010 out_rdy  input  1  shared sink ready.
REQ-011 out_msg  output  p_msg_sz  buffered message.
REQ-012 out_id  output  p_id_sz  index of the requester that produced out_msg.
REQ-013 count  output  16  number of messages delivered on the output port.

Function
REQ-014 Transfer on a port occurs in a cycle where val and rdy are both high at the rising edge.
REQ-015 Block SHALL hold a one-entry output buffer (full flag, msg, id); out_val SHALL equal full.
REQ-016 can_accept = !full || out_rdy; enqueue and dequeue in the same cycle SHALL be allowed (buffer stays full with new data).
REQ-017 Grant: first requester i with in_val[i]=1 scanning ptr, ptr+1, ... mod p_num_reqs; no grant if all in_val low.
REQ-018 in_rdy[i] = can_accept && grant[i]; combinational path in_val -> in_rdy is permitted; no path out_rdy -> out_val.
REQ-019 On input transfer from requester g: buffer <= {in_msg[g], g}, ptr <= (g+1) mod p_num_reqs (wraps p_num_reqs-1 -> 0).
REQ-020 ptr SHALL NOT change in cycles without an input transfer.
REQ-021 Latency: message accepted in cycle N SHALL appear on out_val/out_msg/out_id in cycle N+1.
REQ-022 While full && !out_rdy, out_msg/out_id SHALL remain stable and all in_rdy SHALL be low.
REQ-023 count SHALL increment by 1 on each output transfer and saturate at 16'hFFFF.
REQ-024 Requester holding in_val low is skipped with no cycle penalty; a sole active requester SHALL achieve one message per cycle when out_rdy stays high.
REQ-025 Fairness: a continuously valid requester SHALL be granted within p_num_reqs input transfers.

Reset
REQ-026 While reset is low: full=0, out_val=0, out_msg=0, out_id=0, ptr=0, count=0, in_rdy=0, asynchronously.
REQ-027 Reset asserted mid-operation SHALL discard the buffered message; no partial delivery after deassertion.
REQ-028 First grant after reset deassertion SHALL use ptr=0.

Structure
REQ-029 Shared package vc_test_arb_pkg SHALL hold p_id_sz derivation helper and count width constant (16) and saturation value.
REQ-030 One sub-module vc_rr_arb_comb: combinational round-robin picker (inputs req, ptr; outputs one-hot grant, encoded id, any).
REQ-031 Buffer, ptr, and count registers SHALL reside in vc_test_sink_arb; target 120-400 lines total RTL.

Verification
REQ-032 Single stream: in_val=4'b0001, msgs 8'h11,8'h22,8'h33, out_rdy=1 -> out_msg 11,22,33 on consecutive cycles, out_id=0, count=3.
REQ-033 All valid: in_val=4'b1111 held, out_rdy=1 -> out_id sequence 0,1,2,3,0,1; ptr wraps 3->0.
REQ-034 Backpressure: buffer full with 8'hAA id 2, out_rdy=0 for 5 cycles -> out_msg/out_id stable, in_rdy=0000; out_rdy=1 -> AA delivered, next message enqueued same cycle.
REQ-035 Sparse: ptr=1, in_val=4'b0001 -> requester 0 granted immediately, ptr becomes 1.
REQ-036 Reset mid-stream: full buffer, reset low for 1 cycle -> out_val=0, count=0, next grant from requester 0.
REQ-037 Saturation: force 65537 output transfers -> count stays 16'hFFFF.
